// File: rtl/oam_dma_controller_pkg.sv
// Shared types and constants for the OAM DMA controller.
// Optional build macro OAM_DMA_START_DELAY_EN (used by the top) inserts a
// dead START cycle before the first source read of every transfer.
package oam_dma_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    READ,
    LATCH,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_BASE_ADDR     = 16'hFE00;
  localparam logic [15:0] DMA_REG_ADDR      = 16'hFF46;
  localparam logic [7:0]  ECHO_REMAP_OFFSET = 8'h20;
  localparam logic [7:0]  CPU_BLOCKED_RDATA = 8'hFF;
  localparam logic [7:0]  ECHO_PAGE_FIRST   = 8'hE0;

  // Pages in echo RAM (E0..FF) alias work RAM 0x20 pages lower.
  function automatic logic [7:0] remap_page(input logic [7:0] page);
    return (page >= ECHO_PAGE_FIRST) ? (page - ECHO_REMAP_OFFSET) : page;
  endfunction

endpackage

// File: rtl/oam_dma_controller_cpu_gate.sv
// dma_cpu_gate: combinational CPU access gate used while OAM DMA owns the
// memory port. Only the IO/high-RAM page (the page holding the DMA register)
// stays reachable; everything else reads as 0xFF and writes are dropped.
// Allowed accesses are not forwarded to memory either: the port belongs to
// the DMA, and the surrounding integration routes those to the IO port.
module dma_cpu_gate
  import oam_dma_controller_pkg::*;
(
  input  logic        active,
  input  logic [15:0] cpu_address,
  input  logic        cpu_OE,
  input  logic        cpu_WE,
  input  logic [7:0]  mem_rdata,
  output logic        oe_gated,
  output logic        we_gated,
  output logic [7:0]  cpu_rdata
);

  logic allowed;
  logic blocked;

  // Region decode and masking of CPU enables / read data during a transfer.
  always_comb begin
    allowed   = (cpu_address[15:8] == DMA_REG_ADDR[15:8]);
    blocked   = active && !allowed;
    oe_gated  = cpu_OE && !active;
    we_gated  = cpu_WE && !active;
    cpu_rdata = blocked ? CPU_BLOCKED_RDATA : mem_rdata;
  end

endmodule

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: sequences the OAM DMA copy triggered by a write to
// 0xFF46 and arbitrates the single memory port between CPU and DMA.
// Each byte takes READ (address out), LATCH (capture data), WRITE (to OAM).
// Build macro OAM_DMA_START_DELAY_EN adds one START dead cycle on entry.
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter int          OAM_LEN  = 160,
  parameter logic [15:0] OAM_BASE = OAM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_start,
  input  logic [7:0]  dma_page,
  input  logic [15:0] cpu_address,
  input  logic        cpu_OE,
  input  logic        cpu_WE,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_address,
  output logic        mem_OE,
  output logic        mem_WE,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

`ifdef OAM_DMA_START_DELAY_EN
  localparam dma_state_t ENTRY_STATE = START;
`else
  localparam dma_state_t ENTRY_STATE = READ;
`endif

  dma_state_t  state;
  logic [7:0]  idx;
  logic [7:0]  page_q;
  logic [7:0]  byte_q;
  logic        oe_gated;
  logic        we_gated;

  dma_cpu_gate u_gate (
    .active      (dma_active),
    .cpu_address (cpu_address),
    .cpu_OE      (cpu_OE),
    .cpu_WE      (cpu_WE),
    .mem_rdata   (mem_rdata),
    .oe_gated    (oe_gated),
    .we_gated    (we_gated),
    .cpu_rdata   (cpu_rdata)
  );

  // Transfer FSM; a start pulse in any state (re)starts from byte 0 and
  // suppresses the done pulse of whatever transfer it interrupts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 8'd0;
      page_q     <= 8'd0;
      byte_q     <= 8'd0;
      dma_active <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      if (dma_start) begin
        page_q     <= remap_page(dma_page);
        idx        <= 8'd0;
        state      <= ENTRY_STATE;
        dma_active <= 1'b1;
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          START: state <= READ;
          READ:  state <= LATCH;
          LATCH: begin
            byte_q <= mem_rdata;
            state  <= WRITE;
          end
          WRITE: begin
            if (idx == LAST_IDX) begin
              idx        <= 8'd0;
              state      <= IDLE;
              dma_active <= 1'b0;
              dma_done   <= 1'b1;
            end else begin
              idx   <= idx + 8'd1;
              state <= READ;
            end
          end
          default: begin
            state      <= IDLE;
            dma_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Memory port mux: CPU pass-through unless the DMA is driving a byte.
  always_comb begin
    mem_address = cpu_address;
    mem_OE      = oe_gated;
    mem_WE      = we_gated;
    mem_wdata   = cpu_wdata;
    case (state)
      READ, LATCH: begin
        mem_address = {page_q, idx};
        mem_OE      = 1'b1;
        mem_WE      = 1'b0;
        mem_wdata   = byte_q;
      end
      WRITE: begin
        mem_address = OAM_BASE + {8'h00, idx};
        mem_OE      = 1'b0;
        mem_WE      = 1'b1;
        mem_wdata   = byte_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the OAM DMA transfer started by a CPU write to 0xFF46: copies OAM_LEN bytes from {page, 8'h00} to OAM_BASE.
- Sits between the CPU and the memory unit's CPU port and arbitrates that single port.
- While a transfer is active, CPU accesses are restricted to IO and high RAM.

Parameters:
- OAM_LEN, 160, number of bytes copied per transfer (1..256).
- OAM_BASE, 16'hFE00, destination base address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- dma_start  in  1  one-cycle pulse when the CPU writes 0xFF46
- dma_page  in  8  source page (0xFF46 data), sampled when dma_start=1
- cpu_address  in  16  CPU address
- cpu_OE  in  1  CPU read enable
- cpu_WE  in  1  CPU write enable
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data returned to the CPU
- mem_address  out  16  address to the memory unit
- mem_OE  out  1  read enable to the memory unit
- mem_WE  out  1  write enable to the memory unit
- mem_wdata  out  8  write data to the memory unit
- mem_rdata  in  8  memory unit read data (valid one cycle after the address is presented)
- dma_active  out  1  transfer in progress
- dma_done  out  1  one-cycle pulse after the final OAM write

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - state=IDLE, idx=0, page_q=0, byte_q=0
  - dma_active=0, dma_done=0
  - mem_* follow the CPU (pass-through); cpu_rdata=mem_rdata
- Page remap at sample time:
  - page >= 8'hE0 → page - 8'h20 (echo RAM)
  - all other pages are used unchanged
- States:
  - IDLE: pass-through. On dma_start, latch the remapped page, set idx=0, go to READ. dma_active rises in the cycle after the pulse.
  - READ: mem_address={page_q, idx}, mem_OE=1, mem_WE=0. Next state is LATCH.
  - LATCH: mem_address held, mem_OE=1. byte_q <= mem_rdata at the clock edge. Next state is WRITE.
  - WRITE: mem_address=OAM_BASE+idx, mem_WE=1, mem_OE=0, mem_wdata=byte_q.
    - If idx==OAM_LEN-1: go to IDLE, pulse dma_done for one cycle, clear idx.
    - Otherwise: idx++, go to READ.
- Transfer length: 3 cycles per byte, so OAM_LEN=160 takes 480 cycles from the first READ to the final WRITE inclusive.
- idx is 8 bits. OAM_BASE+idx is computed in 16 bits with no wrap beyond 0xFEFF when OAM_LEN<=256.
- CPU access while dma_active:
  - Allowed region: 0xFF00..0xFFFF (IO, high RAM, IE).
    - These accesses cannot reach memory this cycle (the port is owned by DMA).
    - The integration layer routes them directly to the IO/high-RAM port; this block marks them allowed only.
  - Blocked region: all other addresses.
    - Reads return cpu_rdata=8'hFF.
    - Writes are dropped (never reach mem_WE).
- dma_start while active (simultaneous events):
  - Restart: latch the new page, idx=0, go to READ.
  - dma_active stays high; no dma_done for the aborted transfer.
- dma_start in the same cycle as the final WRITE: restart wins and dma_done is suppressed.
- rst asserted mid-transfer: immediately returns to IDLE. The partially copied OAM is left as is.

Optional Feature:
- Macro: OAM_DMA_START_DELAY_EN.
- Defined: IDLE→START→READ, where START is one dead cycle.
  - dma_active is already high in START, and CPU blocking applies.
  - A transfer is 481 cycles.
  - A restart also passes through START.
- Undefined: IDLE→READ directly, as described above.

Decomposition:
- Shared package:
  - dma_state_t enum (IDLE, START, READ, LATCH, WRITE)
  - OAM_BASE_ADDR, DMA_REG_ADDR (16'hFF46), ECHO_REMAP_OFFSET (8'h20), CPU_BLOCKED_RDATA (8'hFF)
- One natural sub-module: dma_cpu_gate, the combinational allowed/blocked address decode and the CPU read/write masking.
- The FSM and counters stay in the top module.

Test Plan:
- Start with dma_page=8'hC0, memory C000..C09F = i ^ 8'h5A → after 480 cycles, OAM[i] = i ^ 8'h5A for i=0..159. dma_done pulses exactly once; dma_active low the next cycle.
- dma_page=8'hE1 → source reads hit 0xC100..0xC19F; mem_address never shows 0xE1xx.
- CPU read of 0xC000 mid-transfer → cpu_rdata=8'hFF. CPU write 0x33 to 0xC000 mid-transfer → no mem_WE outside DMA WRITE cycles, and C000 unchanged.
- Second dma_start (page 8'h80) at idx=50 → next READ address 0x8000. Total cycles from the restart to dma_done = 480. Only one dma_done pulse overall.
- rst pulse at idx=10 → state IDLE, dma_active=0, pass-through restored. OAM[0..9] written, OAM[10..159] untouched.
- OAM_DMA_START_DELAY_EN defined → first READ occurs 2 cycles after dma_start, and total active time is 481 cycles.
